// File: rtl/phase_pair_pkg.sv
// Shared constants, mode enum and parameter sanity check for the phase pair generator.
package phase_pair_pkg;

  localparam int DEF_HALF_PERIOD = 60;
  localparam int DEF_PHASE_W     = 8;
  localparam int DEF_DWELL       = 1000;

  typedef enum logic {
    MODE_MANUAL = 1'b0,
    MODE_SWEEP  = 1'b1
  } mode_e;

  function automatic int period_of(int half_period);
    return 2 * half_period;
  endfunction

  // Phase register must hold every offset 0..PERIOD-1.
  function automatic bit phase_w_ok(int phase_w, int half_period);
    return (half_period >= 2) && ((1 << phase_w) >= period_of(half_period));
  endfunction

endpackage

// File: rtl/phase_step_ctrl.sv
// Phase register with manual step pending flags, sweep dwell counter and wrap pulse.
module phase_step_ctrl
  import phase_pair_pkg::*;
#(
  parameter int HALF_PERIOD = DEF_HALF_PERIOD,
  parameter int PHASE_W     = DEF_PHASE_W,
  parameter int DWELL       = DEF_DWELL
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               eop,
  input  logic               step_up,
  input  logic               step_dn,
  input  logic               sweep_en,
  output logic [PHASE_W-1:0] phase,
  output logic               sweep_wrap
);

  localparam int P    = period_of(HALF_PERIOD);
  localparam int DW_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [PHASE_W-1:0] P_LAST  = PHASE_W'(P - 1);
  localparam logic [DW_W-1:0]    DW_LAST = DW_W'(DWELL - 1);

  mode_e              mode_q, mode_now;
  logic               up_pend, dn_pend, up_nx, dn_nx, up_any, dn_any, wrap_nx;
  logic [DW_W-1:0]    dwell, dwell_nx;
  logic [PHASE_W-1:0] phase_nx;

  assign mode_now = sweep_en ? MODE_SWEEP : MODE_MANUAL;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q     <= MODE_MANUAL;
      up_pend    <= 1'b0;
      dn_pend    <= 1'b0;
      dwell      <= '0;
      phase      <= '0;
      sweep_wrap <= 1'b0;
    end else begin
      mode_q     <= mode_now;
      up_pend    <= up_nx;
      dn_pend    <= dn_nx;
      dwell      <= dwell_nx;
      phase      <= phase_nx;
      sweep_wrap <= wrap_nx;
    end
  end

  always_comb begin
    phase_nx = phase;
    up_nx    = up_pend;
    dn_nx    = dn_pend;
    dwell_nx = dwell;
    wrap_nx  = 1'b0;
    up_any   = up_pend | step_up;
    dn_any   = dn_pend | step_dn;
    // A mode change discards stale requests and restarts the dwell; phase is kept.
    if (mode_now != mode_q) begin
      up_nx    = 1'b0;
      dn_nx    = 1'b0;
      dwell_nx = '0;
    end else if (mode_q == MODE_SWEEP) begin
      if (eop) begin
        if (dwell == DW_LAST) begin
          dwell_nx = '0;
          phase_nx = (phase == P_LAST) ? '0 : phase + 1'b1;
          wrap_nx  = (phase == P_LAST);
        end else begin
          dwell_nx = dwell + 1'b1;
        end
      end
    end else if (eop) begin
      up_nx = 1'b0;
      dn_nx = 1'b0;
      if (up_any && !dn_any)
        phase_nx = (phase == P_LAST) ? '0 : phase + 1'b1;
      else if (dn_any && !up_any)
        phase_nx = (phase == '0) ? P_LAST : phase - 1'b1;
    end else begin
      up_nx = up_any;
      dn_nx = dn_any;
    end
  end

endmodule

// File: rtl/phase_pair_gen.sv
// Two equal-frequency square waves; sig_out lags ref_out by a programmable phase.
module phase_pair_gen
  import phase_pair_pkg::*;
#(
  parameter int HALF_PERIOD = DEF_HALF_PERIOD,
  parameter int PHASE_W     = DEF_PHASE_W,
  parameter int DWELL       = DEF_DWELL
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               sweep_en,
  input  logic               step_up,
  input  logic               step_dn,
  output logic               ref_out,
  output logic               sig_out,
  output logic [PHASE_W-1:0] phase_cur,
  output logic               sweep_wrap
);

  localparam int P = period_of(HALF_PERIOD);
  localparam logic [PHASE_W-1:0] P_LAST = PHASE_W'(P - 1);
  localparam logic [PHASE_W:0]   P_EXT  = (PHASE_W + 1)'(P);
  localparam logic [PHASE_W:0]   HP_EXT = (PHASE_W + 1)'(HALF_PERIOD);

  if (!phase_w_ok(PHASE_W, HALF_PERIOD)) begin : g_bad_params
    $error("phase_pair_gen: PHASE_W too narrow or HALF_PERIOD < 2");
  end

  logic [PHASE_W-1:0] cnt, phase;
  logic [PHASE_W:0]   diff, d;
  logic               eop;

  assign eop = en && (cnt == P_LAST);

  phase_step_ctrl #(
    .HALF_PERIOD (HALF_PERIOD),
    .PHASE_W     (PHASE_W),
    .DWELL       (DWELL)
  ) u_ctrl (
    .clk        (clk),
    .rst        (rst),
    .eop        (eop),
    .step_up    (step_up),
    .step_dn    (step_dn),
    .sweep_en   (sweep_en),
    .phase      (phase),
    .sweep_wrap (sweep_wrap)
  );

  // One extra bit exposes the borrow; adding P back keeps d in 0..P-1 for any P.
  always_comb begin
    diff = {1'b0, cnt} - {1'b0, phase};
    d    = diff[PHASE_W] ? diff + P_EXT : diff;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      ref_out   <= 1'b1;
      sig_out   <= 1'b1;
      phase_cur <= '0;
    end else if (en) begin
      cnt       <= (cnt == P_LAST) ? '0 : cnt + 1'b1;
      ref_out   <= ({1'b0, cnt} < HP_EXT);
      sig_out   <= (d < HP_EXT);
      phase_cur <= phase;
    end
  end

endmodule

// File: tb/tb_phase_pair_gen.sv
// Randomised and directed bench for phase_pair_gen against an arithmetic reference model.
module tb_phase_pair_gen;

  localparam int H  = 4;
  localparam int P  = 8;
  localparam int DW = 2;
  localparam int PW = 3;

  logic clk, rst, en, sweep_en, step_up, step_dn;
  logic ref_out, sig_out, sweep_wrap;
  logic [PW-1:0] phase_cur;
  logic [5:0] dut_vec;

  int checks = 0;
  int errors = 0;

  // reference model state
  int m_cnt, m_phase, m_dwell;
  bit m_up, m_dn, m_mode;
  logic exp_ref, exp_sig, exp_wrap;
  logic [PW-1:0] exp_phc;

  phase_pair_gen #(.HALF_PERIOD(H), .PHASE_W(PW), .DWELL(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .sweep_en   (sweep_en),
    .step_up    (step_up),
    .step_dn    (step_dn),
    .ref_out    (ref_out),
    .sig_out    (sig_out),
    .phase_cur  (phase_cur),
    .sweep_wrap (sweep_wrap)
  );

  assign dut_vec = {ref_out, sig_out, sweep_wrap, phase_cur};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [5:0] exp_vec();
    return {exp_ref, exp_sig, exp_wrap, exp_phc};
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_phase = 0; m_dwell = 0; m_up = 0; m_dn = 0; m_mode = 0;
    exp_ref = 1'b1; exp_sig = 1'b1; exp_wrap = 1'b0; exp_phc = '0;
  endtask

  // Advance the model by one clock using current inputs, then step the DUT.
  task automatic tick();
    bit upd, ua, da;
    int ncnt;
    upd = en && (m_cnt == P - 1);
    ncnt = m_cnt;
    exp_wrap = 1'b0;
    if (en) begin
      exp_ref = (m_cnt < H);
      exp_sig = (((m_cnt - m_phase + P) % P) < H);
      exp_phc = PW'(m_phase);
      ncnt = (m_cnt + 1) % P;
    end
    if (sweep_en != m_mode) begin
      m_up = 0; m_dn = 0; m_dwell = 0; m_mode = sweep_en;
    end else if (sweep_en) begin
      if (upd) begin
        if (m_dwell == DW - 1) begin
          m_dwell = 0;
          exp_wrap = (m_phase == P - 1);
          m_phase = (m_phase + 1) % P;
        end else m_dwell++;
      end
    end else begin
      ua = m_up | step_up;
      da = m_dn | step_dn;
      if (upd) begin
        if (ua && !da) m_phase = (m_phase + 1) % P;
        else if (da && !ua) m_phase = (m_phase + P - 1) % P;
        m_up = 0; m_dn = 0;
      end else begin
        m_up = ua; m_dn = da;
      end
    end
    m_cnt = ncnt;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; sweep_en = 1'b0; step_up = 1'b0; step_dn = 1'b0;
    model_reset();
    #12;
    checks++;
    if (dut_vec !== 6'b110000) begin errors++; $display("FAIL reset_state: got %b exp 110000", dut_vec); end
    @(posedge clk); #1;
    rst = 1'b0; en = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      tick();
      checks++;
      if (dut_vec !== exp_vec()) begin errors++; $display("FAIL reset_run k=%0d: got %b exp %b", k, dut_vec, exp_vec()); end
      checks++;
      if (ref_out !== (((k - 1) % P) < H) || sig_out !== ref_out) begin
        errors++; $display("FAIL reset_wave k=%0d: ref=%b sig=%b exp both %b", k, ref_out, sig_out, (((k - 1) % P) < H));
      end
    end
  endtask

  task automatic test_manual_step();
    bit rh[$], sh[$];
    do_reset(); en = 1'b1; sweep_en = 1'b0;
    for (int s = 0; s < 3; s++) begin
      for (int c = 0; c < P; c++) begin
        step_up = (m_cnt == 2);
        tick();
        step_up = 1'b0;
        rh.push_back(ref_out); sh.push_back(sig_out);
        checks++;
        if (dut_vec !== exp_vec()) begin errors++; $display("FAIL manual_step s=%0d c=%0d: got %b exp %b", s, c, dut_vec, exp_vec()); end
        if (c == 0) begin
          checks++;
          if (phase_cur !== PW'(s)) begin errors++; $display("FAIL manual_one_per_boundary s=%0d: got %0d exp %0d", s, phase_cur, s); end
        end
      end
    end
    for (int c = 0; c < 24; c++) begin
      tick();
      rh.push_back(ref_out); sh.push_back(sig_out);
      checks++;
      if (dut_vec !== exp_vec()) begin errors++; $display("FAIL manual_hold c=%0d: got %b exp %b", c, dut_vec, exp_vec()); end
    end
    checks++;
    if (phase_cur !== 3'd3) begin errors++; $display("FAIL manual_phase3: got %0d exp 3", phase_cur); end
    for (int t = rh.size() - 16; t < rh.size(); t++) begin
      checks++;
      if (sh[t] != rh[t - 3]) begin errors++; $display("FAIL manual_lag3 t=%0d: sig=%b ref_minus3=%b", t, sh[t], rh[t - 3]); end
    end
    for (int w = 0; w < 2; w++) begin
      int last = -1;
      for (int i = 1; i < rh.size(); i++) begin
        bit a, b;
        a = w ? sh[i] : rh[i];
        b = w ? sh[i - 1] : rh[i - 1];
        if (a != b) begin
          if (last >= 0) begin
            checks++;
            if (i - last < H) begin errors++; $display("FAIL manual_runt w=%0d i=%0d: width %0d min %0d", w, i, i - last, H); end
          end
          last = i;
        end
      end
    end
  endtask

  task automatic test_manual_wrap();
    bit rh[$], sh[$];
    do_reset(); en = 1'b1; sweep_en = 1'b0;
    for (int c = 0; c < 24; c++) begin
      step_dn = (c == 2);
      tick();
      step_dn = 1'b0;
      rh.push_back(ref_out); sh.push_back(sig_out);
      checks++;
      if (dut_vec !== exp_vec()) begin errors++; $display("FAIL wrap_dn c=%0d: got %b exp %b", c, dut_vec, exp_vec()); end
    end
    checks++;
    if (phase_cur !== 3'd7) begin errors++; $display("FAIL wrap_phase7: got %0d exp 7", phase_cur); end
    for (int t = rh.size() - 12; t < rh.size() - 1; t++) begin
      checks++;
      if (sh[t] != rh[t + 1]) begin errors++; $display("FAIL wrap_lead1 t=%0d: sig=%b ref_plus1=%b", t, sh[t], rh[t + 1]); end
    end
    // both pulses in one cycle, then both pending in separate cycles
    for (int r = 0; r < 2; r++) begin
      while (m_cnt != 2) begin
        tick();
        checks++;
        if (dut_vec !== exp_vec()) begin errors++; $display("FAIL wrap_align: got %b exp %b", dut_vec, exp_vec()); end
      end
      for (int c = 0; c < 2 * P; c++) begin
        step_up = (c == 0);
        step_dn = (r == 0) ? (c == 0) : (c == 2);
        tick();
        step_up = 1'b0; step_dn = 1'b0;
        checks++;
        if (dut_vec !== exp_vec()) begin errors++; $display("FAIL wrap_both r=%0d c=%0d: got %b exp %b", r, c, dut_vec, exp_vec()); end
      end
      checks++;
      if (phase_cur !== 3'd7) begin errors++; $display("FAIL wrap_both_hold r=%0d: got %0d exp 7", r, phase_cur); end
    end
  endtask

  task automatic test_sweep();
    int wraps = 0;
    int maxp = 0;
    sweep_en = 1'b1;
    do_reset(); en = 1'b1;
    for (int k = 1; k <= 8 * 16 + 6; k++) begin
      step_up = ($urandom_range(0, 3) == 0);
      step_dn = ($urandom_range(0, 3) == 0);
      tick();
      step_up = 1'b0; step_dn = 1'b0;
      if (sweep_wrap === 1'b1) wraps++;
      if (int'(phase_cur) > maxp) maxp = int'(phase_cur);
      checks++;
      if (dut_vec !== exp_vec()) begin errors++; $display("FAIL sweep_model k=%0d: got %b exp %b", k, dut_vec, exp_vec()); end
      checks++;
      if (phase_cur !== PW'(((k - 1) / 16) % 8) || sweep_wrap !== (k == 128)) begin
        errors++; $display("FAIL sweep_sched k=%0d: phase=%0d wrap=%b exp phase=%0d wrap=%b", k, phase_cur, sweep_wrap, ((k - 1) / 16) % 8, (k == 128));
      end
    end
    checks++;
    if (wraps != 1 || maxp != 7) begin errors++; $display("FAIL sweep_wrap_count: wraps=%0d max=%0d exp 1 and 7", wraps, maxp); end
    sweep_en = 1'b0;
  endtask

  task automatic test_enable_freeze();
    logic [5:0] held;
    do_reset(); en = 1'b1; sweep_en = 1'b0;
    for (int c = 0; c < 10; c++) begin
      step_up = (c == 3);
      tick();
      step_up = 1'b0;
      checks++;
      if (dut_vec !== exp_vec()) begin errors++; $display("FAIL en_pre c=%0d: got %b exp %b", c, dut_vec, exp_vec()); end
    end
    held = dut_vec;
    en = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step_dn = (c == 1);
      tick();
      step_dn = 1'b0;
      checks++;
      if (dut_vec !== held || dut_vec !== exp_vec()) begin
        errors++; $display("FAIL en_freeze c=%0d: got %b exp %b", c, dut_vec, exp_vec());
      end
    end
    en = 1'b1;
    for (int c = 0; c < 24; c++) begin
      tick();
      checks++;
      if (dut_vec !== exp_vec()) begin errors++; $display("FAIL en_resume c=%0d: got %b exp %b", c, dut_vec, exp_vec()); end
    end
  endtask

  task automatic test_reset_mid_sweep();
    int guard = 0;
    sweep_en = 1'b1;
    do_reset(); en = 1'b1;
    while (phase_cur !== 3'd5 && guard < 200) begin
      tick(); guard++;
      checks++;
      if (dut_vec !== exp_vec()) begin errors++; $display("FAIL rstsw_pre g=%0d: got %b exp %b", guard, dut_vec, exp_vec()); end
    end
    checks++;
    if (phase_cur !== 3'd5) begin errors++; $display("FAIL rstsw_reach5: got %0d after %0d cycles", phase_cur, guard); end
    repeat (7) tick();
    rst = 1'b1;
    #2;
    checks++;
    if (dut_vec !== 6'b110000) begin errors++; $display("FAIL rstsw_async: got %b exp 110000", dut_vec); end
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      checks++;
      if (dut_vec !== exp_vec() || phase_cur !== PW'(k >= 17)) begin
        errors++; $display("FAIL rstsw_dwell k=%0d: got %b exp %b", k, dut_vec, exp_vec());
      end
    end
    sweep_en = 1'b0;
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      en      = ($urandom_range(0, 7) != 0);
      step_up = ($urandom_range(0, 4) == 0);
      step_dn = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 39) == 0) sweep_en = ~sweep_en;
      tick();
      checks++;
      if (dut_vec !== exp_vec()) begin errors++; $display("FAIL random c=%0d: got %b exp %b", c, dut_vec, exp_vec()); end
    end
    step_up = 1'b0; step_dn = 1'b0;
  endtask

  initial begin
    test_reset();
    test_manual_step();
    test_manual_wrap();
    test_sweep();
    test_enable_freeze();
    test_reset_mid_sweep();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
